host_mem_responder: RTL and testbench

HOST_MEM_RESPONDER -- requirements
Module: host_mem_responder

---
 rtl/host_mem_responder.sv | 151 +++++++++++++++
 tb/tb_host_mem_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_mem_responder.sv
// host_mem_responder: latency-modelled host memory responder with a preloadable line store
module host_mem_responder #(
  parameter int READ_LAT   = 4,
  parameter int WRITE_LAT  = 2,
  parameter int LINE_AW    = 6,
  parameter int INIT_DELAY = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [63:0]        cpu_addr,
  input  logic               host_rgo,
  input  logic               host_wgo,
  input  logic               host_re,
  input  logic               host_we,
  input  logic [511:0]       host_data_bus_write_out,
  input  logic               ld_en,
  input  logic [LINE_AW-1:0] ld_addr,
  input  logic [511:0]       ld_data,
  output logic               host_init,
  output logic               host_rd_ready,
  output logic               host_wr_ready,
  output logic [511:0]       host_data_bus_read_in,
  output logic [511:0]       wr_log_data,
  output logic               wr_log_valid,
  output logic [15:0]        rd_count,
  output logic [15:0]        wr_count,
  output logic               addr_err
);
  typedef enum logic [2:0] {IDLE, RWAIT, RRDY, WWAIT, WRDY, WDONE} state_t;
  state_t              state_q, state_d;
  logic [7:0]          init_cnt_q, init_cnt_d, lat_q, lat_d;
  logic                init_q, init_d;
  logic [LINE_AW-1:0]  idx_q, idx_d;
  logic                oor_q, oor_d, err_q, err_d;
  logic [15:0]         rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [511:0]        rdata_q, rdata_d, log_q, log_d;
  logic                log_v_q, log_v_d;
  logic                mem_we;
  logic                addr_oor;
  logic [511:0]        rd_line;
  logic                unused_addr;
  logic [511:0]        mem [2**LINE_AW];

  // Byte offset within a line carries no information for a line-granular store.
  assign unused_addr = ^cpu_addr[5:0];
  assign addr_oor    = |cpu_addr[63:LINE_AW+6];
  // A preload landing on the same edge as the read sample is forwarded so it is not missed.
  assign rd_line     = (ld_en && ld_addr == idx_q) ? ld_data : mem[idx_q];

  assign host_init             = init_q;
  assign host_rd_ready         = state_q == RRDY;
  assign host_wr_ready         = state_q == WRDY;
  assign host_data_bus_read_in = rdata_q;
  assign wr_log_data           = log_q;
  assign wr_log_valid          = log_v_q;
  assign rd_count              = rd_cnt_q;
  assign wr_count              = wr_cnt_q;
  assign addr_err              = err_q;

  // Init delay, request acceptance, latency countdown and handshake completion.
  always_comb begin
    init_cnt_d = init_q ? init_cnt_q : init_cnt_q + 8'd1;
    init_d     = init_q | (init_cnt_q == 8'(INIT_DELAY - 1));
    state_d    = state_q;
    lat_d      = lat_q;
    idx_d      = idx_q;
    oor_d      = oor_q;
    err_d      = err_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    rdata_d    = '0;
    log_d      = log_q;
    log_v_d    = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_q && (host_rgo || host_wgo)) begin
          state_d = host_rgo ? RWAIT : WWAIT;
          lat_d   = host_rgo ? 8'(READ_LAT) : 8'(WRITE_LAT);
          idx_d   = cpu_addr[LINE_AW+5:6];
          oor_d   = addr_oor;
          err_d   = err_q | addr_oor;
        end
      end
      RWAIT: begin
        lat_d = lat_q - 8'd1;
        if (lat_q == 8'd1) begin
          state_d = RRDY;
          rdata_d = oor_q ? '0 : rd_line;
        end
      end
      RRDY: begin
        rdata_d  = host_re ? '0 : rdata_q;
        rd_cnt_d = host_re ? rd_cnt_q + 16'd1 : rd_cnt_q;
        state_d  = host_re ? IDLE : RRDY;
      end
      WWAIT: begin
        lat_d   = lat_q - 8'd1;
        state_d = (lat_q == 8'd1) ? WRDY : WWAIT;
      end
      WRDY: begin
        if (host_we) begin
          mem_we   = !oor_q;
          log_d    = host_data_bus_write_out;
          log_v_d  = 1'b1;
          wr_cnt_d = wr_cnt_q + 16'd1;
          state_d  = WDONE;
        end
      end
      WDONE: state_d = host_wgo ? WDONE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset discards any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      init_cnt_q <= '0;
      init_q     <= 1'b0;
      lat_q      <= '0;
      idx_q      <= '0;
      oor_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      rdata_q    <= '0;
      log_q      <= '0;
      log_v_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      init_q     <= init_d;
      lat_q      <= lat_d;
      idx_q      <= idx_d;
      oor_q      <= oor_d;
      err_q      <= err_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      rdata_q    <= rdata_d;
      log_q      <= log_d;
      log_v_q    <= log_v_d;
    end
  end

  // Backing store: the host write is issued last so it wins a same-line preload.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (mem_we) mem[idx_q] <= host_data_bus_write_out;
  end
endmodule

// File: tb/tb_host_mem_responder.sv
// tb_host_mem_responder: scoreboard bench with a transaction-level memory model
module tb_host_mem_responder;
  localparam int RL = 4, WL = 2, LAW = 6, ID = 8;

  logic         clk = 0, rst_n = 0;
  logic [63:0]  cpu_addr = '0;
  logic         host_rgo = 0, host_wgo = 0, host_re = 0, host_we = 0, ld_en = 0;
  logic [511:0] host_data_bus_write_out = '0, ld_data = '0;
  logic [LAW-1:0] ld_addr = '0;
  logic         host_init, host_rd_ready, host_wr_ready, wr_log_valid, addr_err;
  logic [511:0] host_data_bus_read_in, wr_log_data;
  logic [15:0]  rd_count, wr_count;

  host_mem_responder #(.READ_LAT(RL), .WRITE_LAT(WL), .LINE_AW(LAW), .INIT_DELAY(ID)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .host_rgo(host_rgo), .host_wgo(host_wgo),
    .host_re(host_re), .host_we(host_we), .host_data_bus_write_out(host_data_bus_write_out),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .host_init(host_init),
    .host_rd_ready(host_rd_ready), .host_wr_ready(host_wr_ready),
    .host_data_bus_read_in(host_data_bus_read_in), .wr_log_data(wr_log_data),
    .wr_log_valid(wr_log_valid), .rd_count(rd_count), .wr_count(wr_count), .addr_err(addr_err));

  always #5 clk = ~clk;

  typedef struct { logic [511:0] data; int cyc; logic err; logic [15:0] cnt; } item_t;
  item_t rd_q[$], wr_q[$];
  logic [511:0] ref_mem [64];
  logic [15:0] m_rd = 0, m_wr = 0;
  logic m_err = 0;
  int cyc = 0, total = 0, bad = 0, m;
  logic rd_prev = 0, wr_prev = 0, wv_prev = 0;

  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int line_of(input logic [63:0] a);
    return int'((a / 64) % 64);
  endfunction

  function automatic logic oor_of(input logic [63:0] a);
    return (a >> (LAW + 6)) != 0;
  endfunction

  task automatic push_rd(input logic [63:0] a, input int acc);
    item_t it;
    m_err   = m_err | oor_of(a);
    it.data = oor_of(a) ? '0 : ref_mem[line_of(a)];
    it.cyc  = acc + RL;
    it.err  = m_err;
    it.cnt  = m_rd;
    m_rd++;
    rd_q.push_back(it);
  endtask

  task automatic push_wr(input logic [63:0] a, input logic [511:0] d, input int acc);
    item_t it;
    m_err = m_err | oor_of(a);
    if (!oor_of(a)) ref_mem[line_of(a)] = d;
    m_wr++;
    it.data = d;
    it.cyc  = acc + WL;
    it.err  = m_err;
    it.cnt  = m_wr;
    wr_q.push_back(it);
  endtask

  task automatic finish_read(input int dly, output int mc);
    int t = 0;
    while (!host_rd_ready && t < 300) begin @(negedge clk); t++; end
    chk("rd_ready_timeout", host_rd_ready, 1);
    repeat (dly) @(negedge clk);
    host_re = 1; host_rgo = 0; mc = cyc;
    @(negedge clk);
    host_re = 0;
  endtask

  task automatic finish_write(input int dly, input int hold, input bit collide);
    int t = 0;
    while (!host_wr_ready && t < 300) begin @(negedge clk); t++; end
    chk("wr_ready_timeout", host_wr_ready, 1);
    repeat (dly) @(negedge clk);
    host_we = 1;
    if (collide) begin
      ld_en = 1; ld_addr = LAW'(line_of(cpu_addr)); ld_data = ~host_data_bus_write_out;
    end
    @(negedge clk);
    host_we = 0; ld_en = 0;
    repeat (hold) begin
      @(negedge clk);
      chk("wdone_no_ready", host_wr_ready, 0);
    end
    host_wgo = 0;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [63:0] a, input int dly, input bit pre, input bit stray);
    logic [511:0] pd;
    pd = rnd512();
    cpu_addr = a; host_rgo = 1;
    if (pre) ref_mem[line_of(a)] = pd;
    push_rd(a, cyc + 1);
    @(negedge clk);
    if (pre) begin ld_en = 1; ld_addr = LAW'(line_of(a)); ld_data = pd; end
    if (stray) host_we = 1;
    host_re = stray;
    @(negedge clk);
    ld_en = 0; host_re = 0; host_we = 0;
    finish_read(dly, m);
  endtask

  task automatic do_write(input logic [63:0] a, input logic [511:0] d, input int dly,
                          input int hold, input bit stray, input bit collide);
    cpu_addr = a; host_data_bus_write_out = d; host_wgo = 1;
    push_wr(a, d, cyc + 1);
    if (stray) begin
      @(negedge clk); host_we = 1; host_re = 1;
      @(negedge clk); host_we = 0; host_re = 0;
    end
    finish_write(dly, hold, collide);
  endtask

  task automatic init_seq(input logic [63:0] a);
    int c0;
    cpu_addr = a; host_rgo = 1; rst_n = 1; c0 = cyc;
    push_rd(a, c0 + ID + 1);
    for (int k = 1; k <= ID + RL + 1; k++) begin
      @(negedge clk);
      chk("init_rise", host_init, k >= ID);
      chk("init_rd_ready", host_rd_ready, k >= ID + RL + 1);
    end
  endtask

  always @(negedge clk) begin
    item_t it;
    if (host_rd_ready && !rd_prev) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        it = rd_q.pop_front();
        chk("rd_data", host_data_bus_read_in, it.data);
        chk("rd_latency", cyc, it.cyc);
        chk("rd_addr_err", addr_err, it.err);
        chk("rd_count_pre", rd_count, it.cnt);
      end
    end
    if (!host_rd_ready) chk("rd_bus_zero", host_data_bus_read_in, 0);
    if (host_wr_ready && !wr_prev) begin
      if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
      else chk("wr_latency", cyc, wr_q[0].cyc);
    end
    if (wr_log_valid) begin
      chk("wr_log_single", wv_prev, 0);
      if (wr_q.size() == 0) chk("wr_log_unexpected", 1, 0);
      else begin
        it = wr_q.pop_front();
        chk("wr_log_data", wr_log_data, it.data);
        chk("wr_count_post", wr_count, it.cnt);
      end
    end
    rd_prev = host_rd_ready; wr_prev = host_wr_ready; wv_prev = wr_log_valid;
  end

  initial begin
    logic [63:0] a;
    logic [511:0] wd;
    repeat (2) @(negedge clk);
    chk("rst_init", host_init, 0);
    chk("rst_rd_ready", host_rd_ready, 0);
    chk("rst_wr_ready", host_wr_ready, 0);
    chk("rst_rd_bus", host_data_bus_read_in, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst_log_valid", wr_log_valid, 0);
    chk("rst_log_data", wr_log_data, 0);
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = (i == 3) ? {64{8'hA5}} : rnd512();
      ld_en = 1; ld_addr = LAW'(i); ld_data = ref_mem[i];
      @(negedge clk);
    end
    ld_en = 0;
    init_seq(64'hC0);
    finish_read(0, m);
    chk("read_count_one", rd_count, 1);
    chk("read_back_idle", host_rd_ready, 0);
    do_write(64'h40, 512'({32'h0, 16'h1020, 16'h0042}), 1, 8, 0, 0);
    chk("write_count_one", wr_count, 1);
    do_read(64'h40, 0, 0, 0);
    wd = rnd512();
    cpu_addr = 64'h80; host_data_bus_write_out = wd; host_rgo = 1; host_wgo = 1;
    push_rd(64'h80, cyc + 1);
    finish_read(1, m);
    chk("prio_write_waits", host_wr_ready, 0);
    push_wr(64'h80, wd, m + 2);
    finish_write(0, 0, 0);
    do_read(64'h80, 0, 0, 0);
    do_read(64'h140, 0, 1, 1);
    do_read(64'h10000, 0, 0, 0);
    chk("range_err_sticky", addr_err, 1);
    do_write(64'h10000, rnd512(), 0, 1, 0, 0);
    do_read(64'h0, 0, 0, 0);
    do_write(64'h100, rnd512(), 0, 0, 0, 1);
    do_read(64'h100, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      a = 64'($urandom_range(0, 7)) * 64 + 64'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | (64'd1 << $urandom_range(12, 63));
      if ($urandom_range(0, 1) == 1)
        do_read(a, $urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      else
        do_write(a, rnd512(), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3) == 0, !oor_of(a) && $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) begin
        ld_addr = LAW'($urandom_range(0, 7)); ld_data = rnd512(); ld_en = 1;
        ref_mem[int'(ld_addr)] = ld_data;
        @(negedge clk);
        ld_en = 0;
      end
    end
    cpu_addr = 64'h1C0; host_rgo = 1;
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrst_init", host_init, 0);
    chk("midrst_rd_ready", host_rd_ready, 0);
    chk("midrst_rd_count", rd_count, 0);
    chk("midrst_wr_count", wr_count, 0);
    chk("midrst_addr_err", addr_err, 0);
    chk("midrst_log_data", wr_log_data, 0);
    rd_q.delete(); wr_q.delete();
    m_rd = 0; m_wr = 0; m_err = 0;
    repeat (2) @(negedge clk);
    chk("midrst_hold_ready", host_rd_ready, 0);
    init_seq(64'h1C0);
    finish_read(0, m);
    do_write(64'h1C0, rnd512(), 0, 0, 0, 0);
    do_read(64'h1C0, 1, 0, 0);
    repeat (4) @(negedge clk);
    chk("rd_q_drained", rd_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("final_rd_count", rd_count, m_rd);
    chk("final_wr_count", wr_count, m_wr);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
